cordic_quad_restore: RTL and testbench

CORDIC_QUAD_RESTORE -- requirements
Module: cordic_quad_restore

---
 rtl/cordic_quad_restore.sv | 118 +++++++++++
 tb/tb_cordic_quad_restore.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cordic_quad_restore.sv
// cordic_quad_restore: restores the quadrant of CORDIC sin/cos results using a tag FIFO fed by the angle-reduction stage.
//   clk, rst            : clock, synchronous active-high reset
//   tag_valid, tag_in   : quadrant tag push (00 Q1, 01 Q2, 10 Q4, 11 Q3)
//   res_valid, cos_in,  : CORDIC result strobe and signed Q2.29 results; each result pops one tag
//   sin_in
//   cos_out, sin_out,   : corrected Q2.29 results, tag used, and one-cycle qualifying strobe
//   quad_out, out_valid
//   tag_count           : tag FIFO occupancy
//   ovf_err, unf_err    : sticky overflow / underflow flags
//   CORDIC_GAIN_COMP_EN : when defined, scales results by 1/K with one extra register stage
module cordic_quad_restore #(
  parameter int TAG_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tag_valid,
  input  logic [1:0]                  tag_in,
  input  logic                        res_valid,
  input  logic [31:0]                 cos_in,
  input  logic [31:0]                 sin_in,
  output logic [31:0]                 cos_out,
  output logic [31:0]                 sin_out,
  output logic                        out_valid,
  output logic [1:0]                  quad_out,
  output logic [$clog2(TAG_DEPTH):0]  tag_count,
  output logic                        ovf_err,
  output logic                        unf_err
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);
  logic [1:0] mem_q [TAG_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty, full, do_push, do_pop, ovf_q, unf_q, v1_q;
  logic [1:0] tag_d, q1_q;
  logic [31:0] c1_d, s1_d, c1_q, s1_q;
  function automatic logic [31:0] neg_sat(input logic [31:0] x);
    return x == 32'h8000_0000 ? 32'h7FFF_FFFF : -x;
  endfunction
  // An empty FIFO with a coinciding push bypasses storage; with no push the result passes uncorrected.
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == FULL;
    do_pop  = res_valid & ~empty;
    do_push = tag_valid & ~(empty & res_valid) & ~(full & ~res_valid);
    tag_d   = ~empty ? mem_q[rd_q] : tag_valid ? tag_in : 2'b00;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    c1_d    = tag_d[0] ? neg_sat(cos_in) : cos_in;
    s1_d    = tag_d[1] ? neg_sat(sin_in) : sin_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      v1_q  <= 1'b0;
      c1_q  <= '0;
      s1_q  <= '0;
      q1_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= tag_in;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_q | (full & tag_valid & ~res_valid);
      unf_q <= unf_q | (empty & res_valid & ~tag_valid);
      v1_q  <= res_valid;
      if (res_valid) begin
        c1_q <= c1_d;
        s1_q <= s1_d;
        q1_q <= tag_d;
      end
    end
  end
`ifdef CORDIC_GAIN_COMP_EN
  logic v2_q;
  logic [1:0] q2_q;
  logic [31:0] c2_q, s2_q;
  // Round-to-nearest multiply by 1/K in Q2.29, saturated back to 32 bits.
  function automatic logic [31:0] gain(input logic [31:0] x);
    logic signed [63:0] p;
    p = ($signed({{32{x[31]}}, x}) * 64'sd326016438 + 64'sd268435456) >>> 29;
    return p > 64'sd2147483647 ? 32'h7FFF_FFFF : p < -64'sd2147483648 ? 32'h8000_0000 : p[31:0];
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
      c2_q <= '0;
      s2_q <= '0;
      q2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        c2_q <= gain(c1_q);
        s2_q <= gain(s1_q);
        q2_q <= q1_q;
      end
    end
  end
  assign cos_out   = c2_q;
  assign sin_out   = s2_q;
  assign quad_out  = q2_q;
  assign out_valid = v2_q;
`else
  assign cos_out   = c1_q;
  assign sin_out   = s1_q;
  assign quad_out  = q1_q;
  assign out_valid = v1_q;
`endif
  assign tag_count = cnt_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
endmodule

// File: tb/tb_cordic_quad_restore.sv
// tb_cordic_quad_restore: directed self-checking bench for cordic_quad_restore with TAG_DEPTH=16.
module tb_cordic_quad_restore;
  logic clk = 1'b0;
  logic rst, tag_valid, res_valid, out_valid, ovf_err, unf_err;
  logic [1:0] tag_in, quad_out;
  logic [31:0] cos_in, sin_in, cos_out, sin_out;
  logic [4:0] tag_count;
  int n_chk = 0;
  int n_fail = 0;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 2;
  localparam logic [31:0] CP = 32'h136E9DB6;
  localparam logic [31:0] CN = 32'hEC91624A;
  localparam logic [31:0] DP = 32'h0DBD95B2;
  localparam logic [31:0] DN = 32'hF2426A4E;
  localparam logic [31:0] SX = 32'h4DBA76D7;
`else
  localparam int LAT = 1;
  localparam logic [31:0] CP = 32'h20000000;
  localparam logic [31:0] CN = 32'hE0000000;
  localparam logic [31:0] DP = 32'h16A09E66;
  localparam logic [31:0] DN = 32'hE95F619A;
  localparam logic [31:0] SX = 32'h7FFFFFFF;
`endif
  logic [31:0] ec [4];
  logic [31:0] es [4];
  cordic_quad_restore #(.TAG_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .tag_valid(tag_valid), .tag_in(tag_in),
    .res_valid(res_valid), .cos_in(cos_in), .sin_in(sin_in),
    .cos_out(cos_out), .sin_out(sin_out), .out_valid(out_valid),
    .quad_out(quad_out), .tag_count(tag_count), .ovf_err(ovf_err), .unf_err(unf_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic pop(input logic [31:0] c, input logic [31:0] s);
    res_valid = 1'b1;
    cos_in = c;
    sin_in = s;
    tick;
    res_valid = 1'b0;
    repeat (LAT - 1) tick;
  endtask
  initial begin
    ec = '{DP, DN, DP, DN};
    es = '{DP, DP, DN, DN};
    rst = 1'b1; tag_valid = 1'b0; res_valid = 1'b0; tag_in = 2'b00; cos_in = '0; sin_in = '0;
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt", 32'(tag_count), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_unf", 32'(unf_err), 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_quad", 32'(quad_out), 0);
    rst = 1'b0;
    tag_valid = 1'b1; tag_in = 2'b01;
    tick;
    tag_valid = 1'b0;
    chk("q2_cnt_push", 32'(tag_count), 1);
    tick;
    tick;
    pop(32'h20000000, 32'h0);
    chk("q2_valid", 32'(out_valid), 1);
    chk("q2_cos", cos_out, CN);
    chk("q2_sin", sin_out, 0);
    chk("q2_quad", 32'(quad_out), 1);
    chk("q2_cnt", 32'(tag_count), 0);
    for (int i = 0; i < 4; i++) begin
      tag_valid = 1'b1; tag_in = 2'(i);
      tick;
    end
    tag_valid = 1'b0;
    chk("ord_cnt_full", 32'(tag_count), 4);
    for (int i = 0; i < 4 + LAT - 1; i++) begin
      res_valid = (i < 4); cos_in = 32'h16A09E66; sin_in = 32'h16A09E66;
      tick;
      if (i >= LAT - 1) begin
        chk($sformatf("ord%0d_valid", i - LAT + 1), 32'(out_valid), 1);
        chk($sformatf("ord%0d_cos", i - LAT + 1), cos_out, ec[i - LAT + 1]);
        chk($sformatf("ord%0d_sin", i - LAT + 1), sin_out, es[i - LAT + 1]);
        chk($sformatf("ord%0d_quad", i - LAT + 1), 32'(quad_out), 32'(i - LAT + 1));
      end
    end
    res_valid = 1'b0;
    tick;
    chk("hold_valid", 32'(out_valid), 0);
    chk("hold_cos", cos_out, DN);
    chk("hold_quad", 32'(quad_out), 3);
    chk("ord_cnt", 32'(tag_count), 0);
    for (int i = 0; i < 17; i++) begin
      tag_valid = 1'b1; tag_in = (i == 16) ? 2'b11 : 2'(i);
      tick;
      if (i == 15) begin
        chk("full_cnt", 32'(tag_count), 16);
        chk("full_ovf", 32'(ovf_err), 0);
      end
    end
    tag_valid = 1'b0;
    chk("ovf_cnt", 32'(tag_count), 16);
    chk("ovf_flag", 32'(ovf_err), 1);
    tag_valid = 1'b1; tag_in = 2'b10; res_valid = 1'b1; cos_in = 32'h20000000; sin_in = 32'h0;
    tick;
    tag_valid = 1'b0; res_valid = 1'b0;
    repeat (LAT - 1) tick;
    chk("fullpp_quad", 32'(quad_out), 0);
    chk("fullpp_cnt", 32'(tag_count), 16);
    for (int j = 1; j <= 16; j++) begin
      pop(32'h20000000, 32'h0);
      chk($sformatf("rb%0d_quad", j), 32'(quad_out), (j == 16) ? 2 : j % 4);
    end
    chk("rb_cnt", 32'(tag_count), 0);
    pop(32'h20000000, 32'h0);
    chk("unf_flag", 32'(unf_err), 1);
    chk("unf_quad", 32'(quad_out), 0);
    chk("unf_cos", cos_out, CP);
    chk("unf_sin", sin_out, 0);
    chk("unf_cnt", 32'(tag_count), 0);
    tag_valid = 1'b1; tag_in = 2'b11; res_valid = 1'b1; cos_in = 32'h20000000; sin_in = 32'h80000000;
    tick;
    chk("byp_cnt", 32'(tag_count), 0);
    tag_valid = 1'b0; res_valid = 1'b0;
    repeat (LAT - 1) tick;
    chk("byp_valid", 32'(out_valid), 1);
    chk("byp_quad", 32'(quad_out), 3);
    chk("byp_cos", cos_out, CN);
    chk("byp_sin", sin_out, SX);
    chk("byp_ovf_sticky", 32'(ovf_err), 1);
    for (int i = 0; i < 5; i++) begin
      tag_valid = 1'b1; tag_in = 2'b01;
      tick;
    end
    tag_valid = 1'b0;
    res_valid = 1'b1; cos_in = 32'h20000000; sin_in = 32'h0;
    tick;
    rst = 1'b1; tag_valid = 1'b1; tag_in = 2'b11;
    tick;
    rst = 1'b0; tag_valid = 1'b0; res_valid = 1'b0;
    chk("rm_valid", 32'(out_valid), 0);
    chk("rm_cnt", 32'(tag_count), 0);
    chk("rm_ovf", 32'(ovf_err), 0);
    chk("rm_unf", 32'(unf_err), 0);
    chk("rm_cos", cos_out, 0);
    chk("rm_quad", 32'(quad_out), 0);
    tag_valid = 1'b1; tag_in = 2'b01;
    tick;
    tag_valid = 1'b0;
    chk("post_rst_push", 32'(tag_count), 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("rm_idle%0d", i), 32'(out_valid), 0);
    end
    pop(32'h20000000, 32'h0);
    chk("post_rst_quad", 32'(quad_out), 1);
    chk("post_rst_cos", cos_out, CN);
    pop(32'h20000000, 32'h0);
    chk("post_rst_stale_quad", 32'(quad_out), 0);
    chk("post_rst_unf", 32'(unf_err), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
